// File: rtl/cstream_pkg.sv
// Shared constants for the character-stream pre-filters.
//   - ASCII codes used by the comment stripper and the int-declaration checker.
//   - FSM state encoding for comment_strip (3-bit).
//   - nl_map(): optional newline/CR to space mapping.
package cstream_pkg;

  localparam logic [7:0] CH_SLASH = 8'h2f;
  localparam logic [7:0] CH_STAR  = 8'h2a;
  localparam logic [7:0] CH_NL    = 8'h0a;
  localparam logic [7:0] CH_CR    = 8'h0d;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_SEMI  = 8'h3b;

  typedef logic [2:0] state_t;

  localparam state_t ST_NORMAL     = 3'd0;
  localparam state_t ST_SLASH      = 3'd1;
  localparam state_t ST_LINE       = 3'd2;
  localparam state_t ST_BLOCK      = 3'd3;
  localparam state_t ST_BLOCK_STAR = 3'd4;
  localparam state_t ST_FLUSH      = 3'd5;

  // Map '\n' and '\r' to ' ' when en is set; every other character passes through.
  function automatic logic [7:0] nl_map(input logic [7:0] c, input logic en);
    if (en && (c == CH_NL || c == CH_CR)) begin
      return CH_SPACE;
    end
    return c;
  endfunction

endpackage

// File: rtl/comment_strip.sv
// comment_strip: removes C comments from a raw ASCII stream.
//   Each completed comment is replaced by one separator character; a lone '/'
//   that does not open a comment is re-emitted together with the following
//   character (which costs one stall cycle while that character is flushed).
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   in           raw input character
//   in_valid     in carries a character this cycle
//   in_ready     block accepts in this cycle (low only while flushing)
//   out          cleaned character, registered, held when out_valid is low
//   out_valid    single-cycle strobe per emitted character
//   in_comment   high while inside a line or block comment
//   comment_cnt  number of completed comments, saturating
module comment_strip
  import cstream_pkg::*;
#(
  parameter int unsigned NL_TO_SPACE = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out,
  output logic             out_valid,
  output logic             in_comment,
  output logic [CNT_W-1:0] comment_cnt
);

  localparam logic NlEn = (NL_TO_SPACE != 0);

  state_t           state_q, state_d;
  logic [7:0]       pending_q, pending_d;
  logic [7:0]       out_q, out_d;
  logic             out_valid_d;
  logic             in_comment_q, in_comment_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_inc;
  logic             accept;

  assign in_ready = (state_q != ST_FLUSH);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    cnt_inc     = 1'b0;

    unique case (state_q)
      ST_NORMAL: begin
        if (accept) begin
          if (in == CH_SLASH) begin
            state_d = ST_SLASH;
          end else begin
            out_valid_d = 1'b1;
            out_d       = nl_map(in, NlEn);
          end
        end
      end
      ST_SLASH: begin
        if (accept) begin
          if (in == CH_SLASH) begin
            state_d = ST_LINE;
          end else if (in == CH_STAR) begin
            state_d = ST_BLOCK;
          end else begin
            // Not a comment: release the held '/' now, the character next cycle.
            out_valid_d = 1'b1;
            out_d       = CH_SLASH;
            pending_d   = in;
            state_d     = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        out_valid_d = 1'b1;
        out_d       = nl_map(pending_q, NlEn);
        state_d     = ST_NORMAL;
      end
      ST_LINE: begin
        if (accept && in == CH_NL) begin
          out_valid_d = 1'b1;
          out_d       = NlEn ? CH_SPACE : CH_NL;
          cnt_inc     = 1'b1;
          state_d     = ST_NORMAL;
        end
      end
      ST_BLOCK: begin
        if (accept && in == CH_STAR) begin
          state_d = ST_BLOCK_STAR;
        end
      end
      ST_BLOCK_STAR: begin
        if (accept) begin
          if (in == CH_SLASH) begin
            out_valid_d = 1'b1;
            out_d       = CH_SPACE;
            cnt_inc     = 1'b1;
            state_d     = ST_NORMAL;
          end else if (in != CH_STAR) begin
            state_d = ST_BLOCK;
          end
        end
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign in_comment_d = (state_d == ST_LINE) || (state_d == ST_BLOCK) ||
                        (state_d == ST_BLOCK_STAR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_NORMAL;
      pending_q    <= 8'h00;
      out_q        <= 8'h00;
      out_valid    <= 1'b0;
      in_comment_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      out_q        <= out_d;
      out_valid    <= out_valid_d;
      in_comment_q <= in_comment_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out         = out_q;
  assign in_comment  = in_comment_q;
  assign comment_cnt = cnt_q;

endmodule

// File: tb/tb_comment_strip.sv
// Self-checking bench for comment_strip. Three instances share one input stream:
// NL_TO_SPACE=1/CNT_W=8, NL_TO_SPACE=0/CNT_W=8 and NL_TO_SPACE=1/CNT_W=2.
module tb_comment_strip;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in;
  logic       in_valid;

  logic       rdy_a, rdy_b, rdy_c;
  logic [7:0] out_a, out_b, out_c;
  logic       ov_a, ov_b, ov_c;
  logic       ic_a, ic_b, ic_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model results
  logic [7:0] m_out[$];
  int         m_cnt;
  bit         m_inc;
  int         m_lone;

  always #5 clk = ~clk;

  comment_strip #(.NL_TO_SPACE(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(rdy_a),
    .out(out_a), .out_valid(ov_a), .in_comment(ic_a), .comment_cnt(cnt_a)
  );
  comment_strip #(.NL_TO_SPACE(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(rdy_b),
    .out(out_b), .out_valid(ov_b), .in_comment(ic_b), .comment_cnt(cnt_b)
  );
  comment_strip #(.NL_TO_SPACE(1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(rdy_c),
    .out(out_c), .out_valid(ov_c), .in_comment(ic_c), .comment_cnt(cnt_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] map_nl(input logic [7:0] c, input bit nl2sp);
    if (nl2sp && (c == 8'h0a || c == 8'h0d)) return 8'h20;
    return c;
  endfunction

  // Whole-string reference: scans the first n characters of s with lookahead,
  // finding each comment's terminator directly.
  function automatic void model(input string s, input int n, input bit nl2sp);
    int i = 0;
    m_out.delete();
    m_cnt  = 0;
    m_inc  = 0;
    m_lone = 0;
    while (i < n) begin
      if (s[i] != 8'h2f) begin
        m_out.push_back(map_nl(s[i], nl2sp));
        i++;
      end else if (i + 1 >= n) begin
        break;  // '/' still held, nothing emitted yet
      end else if (s[i+1] == 8'h2f) begin
        int j = i + 2;
        while (j < n && s[j] != 8'h0a) j++;
        if (j >= n) begin
          m_inc = 1;
          break;
        end
        m_out.push_back(nl2sp ? 8'h20 : 8'h0a);
        m_cnt++;
        i = j + 1;
      end else if (s[i+1] == 8'h2a) begin
        int k = i + 2;
        while (k + 1 < n && !(s[k] == 8'h2a && s[k+1] == 8'h2f)) k++;
        if (k + 1 >= n) begin
          m_inc = 1;
          break;
        end
        m_out.push_back(8'h20);
        m_cnt++;
        i = k + 2;
      end else begin
        m_out.push_back(8'h2f);
        m_lone++;
        i++;
      end
    end
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'($urandom_range(1));
    in       = 8'($urandom);
    @(negedge clk);
    check({tag, " rst out"}, 32'(out_a), 32'h0);
    check({tag, " rst out_valid"}, 32'(ov_a), 32'h0);
    check({tag, " rst in_comment"}, 32'(ic_a), 32'h0);
    check({tag, " rst cnt"}, 32'(cnt_a), 32'h0);
    check({tag, " rst in_ready"}, 32'(rdy_a), 32'h1);
    reset    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic run_seg(input string tag, input string s);
    logic [7:0] got_a[$], got_b[$], got_c[$];
    int  n = s.len();
    int  idx = 0, low = 0, cyc = 0, drain = 0, sz;
    bit  acc;
    do_reset(tag);
    forever begin
      @(negedge clk);
      if (ov_a) got_a.push_back(out_a);
      if (ov_b) got_b.push_back(out_b);
      if (ov_c) got_c.push_back(out_c);
      if (rdy_a) begin
        // One-cycle latency: every accepted character is already visible.
        model(s, idx, 1);
        check({tag, " running len"}, 32'(got_a.size()), 32'(m_out.size()));
        check({tag, " in_comment"}, 32'(ic_a), 32'(m_inc));
        if (idx >= n) drain++;
      end else begin
        low++;
      end
      if (drain > 2) break;
      cyc++;
      if (cyc > 20 * n + 50) begin
        check({tag, " timeout"}, 32'(idx), 32'(n));
        break;
      end
      // Keep in_valid high through a stall so a double-consume would show.
      if (idx < n && (!rdy_a || $urandom_range(3) != 0)) begin
        in       = s[idx];
        in_valid = 1'b1;
      end else begin
        in       = 8'($urandom);
        in_valid = 1'b0;
      end
      acc = in_valid && rdy_a;
      @(posedge clk);
      if (acc) idx++;
    end
    in_valid = 1'b0;

    model(s, n, 1);
    check({tag, " out count"}, 32'(got_a.size()), 32'(m_out.size()));
    sz = (got_a.size() < m_out.size()) ? got_a.size() : m_out.size();
    for (int i = 0; i < sz; i++) check({tag, " out char"}, 32'(got_a[i]), 32'(m_out[i]));
    check({tag, " comment_cnt"}, 32'(cnt_a), 32'(m_cnt));
    check({tag, " final in_comment"}, 32'(ic_a), 32'(m_inc));
    check({tag, " stall cycles"}, 32'(low), 32'(m_lone));
    check({tag, " sat cnt"}, 32'(cnt_c), 32'((m_cnt > 3) ? 3 : m_cnt));
    check({tag, " sat out count"}, 32'(got_c.size()), 32'(m_out.size()));

    model(s, n, 0);
    check({tag, " nl0 out count"}, 32'(got_b.size()), 32'(m_out.size()));
    sz = (got_b.size() < m_out.size()) ? got_b.size() : m_out.size();
    for (int i = 0; i < sz; i++) check({tag, " nl0 char"}, 32'(got_b[i]), 32'(m_out[i]));
    check({tag, " nl0 comment_cnt"}, 32'(cnt_b), 32'(m_cnt));
  endtask

  initial begin
    logic [7:0] alpha[10];
    string      s;
    string      s_line;
    string      s_lone_nl;
    reset    = 1'b0;
    in_valid = 1'b0;
    in       = 8'h00;
    alpha    = '{8'h2f, 8'h2f, 8'h2a, 8'h2a, 8'h0a, 8'h0d, 8'h61, 8'h3b, 8'h20, 8'h78};
    s_line    = $sformatf("int b; // c;%c", 8'h0a);
    s_lone_nl = $sformatf("x/%cy/%cz", 8'h0d, 8'h0a);

    // Directed cases; each runs twice with different random in_valid gaps.
    for (int r = 0; r < 2; r++) begin
      run_seg("plain", "int a;");
      run_seg("block", "int/*x;*/a;");
      run_seg("line", s_line);
      run_seg("lone", "a/b");
      run_seg("empty blk", "/**/");
      run_seg("slash star slash", "/*/x*/");
      run_seg("triple star", "/***/");
      run_seg("mid comment", "/* abc");
      run_seg("after reset", "int c;");
      run_seg("held slash", "ab/");
      run_seg("lone nl", s_lone_nl);
      run_seg("saturate", "/**//**//**//**//**/");
    end

    for (int r = 0; r < 14; r++) begin
      int len = $urandom_range(40, 10);
      s = "";
      for (int i = 0; i < len; i++) s = $sformatf("%s%c", s, alpha[$urandom_range(9)]);
      run_seg($sformatf("rand%0d", r), s);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/comment_strip.md
Name: comment_strip

Overview:
- Upstream pre-filter for the int-declaration checker.
- Consumes a raw 8-bit ASCII character stream and removes C comments (// ... newline and /* ... */).
- Each removed comment becomes a single separator character, and newline/CR are optionally normalised to space.
- Emits a cleaned, one-character-per-beat stream with a valid strobe that gates the checker's character input.

Parameters:
- NL_TO_SPACE, 1: when 1, '\n' (0x0A) and '\r' (0x0D) are emitted as ' ' (0x20); when 0, they pass unchanged.
- CNT_W, 8: width of the saturating completed-comment counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk)
- in  input  8  raw input character
- in_valid  input  1  in carries a character this cycle
- in_ready  output  1  block accepts in this cycle; transfer occurs when in_valid & in_ready
- out  output  8  cleaned character (registered)
- out_valid  output  1  out is valid this cycle; single-cycle strobe per character
- in_comment  output  1  high while inside a line or block comment (registered)
- comment_cnt  output  CNT_W  number of completed comments, saturating at all-ones

Behaviour:
- Reset (reset==0 at posedge): state=NORMAL, out=0, out_valid=0, in_comment=0, comment_cnt=0, pending cleared. Reset mid-comment or with a held '/' discards that context with no output.
- in_ready = 1 in every state except FLUSH. in_ready is combinational from state only, never from in_valid.
- out_valid defaults to 0 each cycle. out holds its last value when out_valid=0.
- Latency: an accepted plain character appears on out/out_valid on the next cycle.
- NL mapping, where it applies below: a '\n' or '\r' is emitted as ' ' when NL_TO_SPACE=1, otherwise unchanged.
- FSM states: NORMAL, SLASH, LINE, BLOCK, BLOCK_STAR, FLUSH. All transitions below occur only on an accepted beat, except in FLUSH.
- NORMAL:
  - '/' -> SLASH, no output.
  - Any other character -> emit it with NL mapping; stay in NORMAL.
- SLASH (a held '/'):
  - '/' -> LINE, in_comment=1, no output.
  - '*' -> BLOCK, in_comment=1, no output.
  - Any other character c -> emit '/', latch pending=c, go to FLUSH.
- FLUSH: in_ready=0. Unconditionally emit pending with NL mapping, then go to NORMAL. pending can never be '/' or '*'.
- LINE:
  - '\n' -> emit ' ' (or '\n' when NL_TO_SPACE=0), in_comment=0, comment_cnt+1, go to NORMAL.
  - Any other character -> dropped, stay in LINE.
- BLOCK:
  - '*' -> BLOCK_STAR.
  - Any other character -> dropped, stay in BLOCK (newlines included).
- BLOCK_STAR:
  - '/' -> emit ' ', in_comment=0, comment_cnt+1, go to NORMAL.
  - '*' -> stay in BLOCK_STAR.
  - Any other character -> BLOCK.
- Characters inside comments (';', ',', letters) never reach out.
- "/*/" does not close a block comment; the closing '/' must follow a '*' received after the opening "/*".
- in_comment is registered and rises on the cycle after the second comment-opening character is accepted.
- comment_cnt saturates at {CNT_W{1'b1}}. At most one increment per cycle.
- in_valid=0 freezes the FSM, counter and pending value. A held '/' in SLASH waits indefinitely.
- No lookahead beyond one character. An unterminated comment remains open until reset.

Decomposition:
- Shared package cstream_pkg:
  - ASCII constants CH_SLASH, CH_STAR, CH_NL, CH_CR, CH_SPACE, CH_SEMI.
  - State encoding for the FSM (3-bit enum).
- No sub-module; single flat module. The saturating counter is inline.

Test Plan:
- Plain stream: "int a;" one char/cycle -> out "int a;" with 1-cycle latency, out_valid high 6 cycles, comment_cnt=0.
- Block comment: "int/*x;*/a;" -> out "int a;", comment_cnt=1, in_comment high from after '*' through the closing '/' accept.
- Line comment: "int b; // c;\n" with NL_TO_SPACE=1 -> out "int b; " then ' ', comment_cnt=1. Repeat with NL_TO_SPACE=0 -> final char 0x0A.
- Lone slash: "a/b" -> out 'a','/','b'. in_ready low exactly one cycle (FLUSH), and the 'b' held on in during that cycle is not double-consumed.
- Edge cases:
  - "/**/" -> single ' ', comment_cnt=1.
  - "/*/x*/" -> single ' '.
  - "/***/" -> single ' '.
  - in_valid gaps inserted inside each case -> identical output sequence.
- Reset mid-comment: "/* abc", reset low 1 cycle, then "int c;" -> out "int c;", in_comment=0, comment_cnt=0. Saturation: CNT_W=2, five "/**/" -> comment_cnt=3.
